// File: rtl/seg_scan_scroll_if.sv
// Bus bundle for seg_scan_scroll: message-buffer write port, scroll control
// and the multiplexed display pins. The master side is the board-level
// controller; the slave side is the display driver.
interface seg_scan_scroll_if #(
    parameter int NUM_DIG = 8,
    parameter int MSG_LEN = 16
);
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [5:0]         wr_data;
    logic               scroll_en;
    logic [7:0]         seg;
    logic [NUM_DIG-1:0] dig;
    logic               frame_tick;

    modport master (
        output wr_en, wr_addr, wr_data, scroll_en,
        input  seg, dig, frame_tick
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, scroll_en,
        output seg, dig, frame_tick
    );
endinterface

// File: rtl/seg_scan_scroll.sv
// Multiplexed common-anode 7-segment driver with a writable message buffer
// and hardware scrolling. Segments and digit enables are active low.
// Optional build macro GHOST_BLANK_EN: blanks every digit slot for its first
// BLANK_CYC cycles to suppress ghosting; without it BLANK_CYC has no effect.
module seg_scan_scroll #(
    parameter int NUM_DIG       = 8,
    parameter int SCAN_DIV      = 32768,
    parameter int MSG_LEN       = 16,
    parameter int SCROLL_FRAMES = 64,
    parameter int BLANK_CYC     = 256
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_scroll_if.slave  bus
);
    localparam int AW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int IW  = $clog2(NUM_DIG);
    localparam int FW  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(NUM_DIG - 1);
    localparam logic [FW-1:0]  FRM_LAST  = FW'(SCROLL_FRAMES - 1);
    localparam logic [AW-1:0]  LEFT_OFS  = AW'(NUM_DIG - 1);
    localparam logic [5:0]     BLANK_ENT = {1'b0, 5'd31};

`ifdef GHOST_BLANK_EN
    localparam int BLANK_WIN = BLANK_CYC;
`else
    // Blanking window collapses to zero length; BLANK_CYC is irrelevant here.
    localparam int BLANK_WIN = 0 * BLANK_CYC;
`endif

    // Character code to active-low g..a pattern.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] pat;
        case (code)
            5'd0:    pat = 7'b1000000;
            5'd1:    pat = 7'b1111001;
            5'd2:    pat = 7'b0100100;
            5'd3:    pat = 7'b0110000;
            5'd4:    pat = 7'b0011001;
            5'd5:    pat = 7'b0010010;
            5'd6:    pat = 7'b0000010;
            5'd7:    pat = 7'b1111000;
            5'd8:    pat = 7'b0000000;
            5'd9:    pat = 7'b0010000;
            5'd10:   pat = 7'b0001000;  // A
            5'd11:   pat = 7'b0000011;  // b
            5'd12:   pat = 7'b1000110;  // C
            5'd13:   pat = 7'b0100001;  // d
            5'd14:   pat = 7'b0000110;  // E
            5'd15:   pat = 7'b0001110;  // F
            5'd16:   pat = 7'b0001001;  // H
            5'd17:   pat = 7'b1000111;  // L
            5'd18:   pat = 7'b0001100;  // P
            5'd19:   pat = 7'b1000001;  // U
            5'd20:   pat = 7'b0001001;  // X (same glyph as H on 7 segments)
            5'd21:   pat = 7'b0111111;  // '-'
            default: pat = 7'b1111111;  // 22..31 blank
        endcase
        return pat;
    endfunction

    logic [SCW-1:0]     scan_cnt_r;
    logic [IW-1:0]      idx_r;
    logic [FW-1:0]      frame_cnt_r;
    logic [AW-1:0]      offset_r;
    logic [5:0]         msg_r [MSG_LEN];
    logic [7:0]         seg_r;
    logic [NUM_DIG-1:0] dig_r;
    logic               frame_tick_r;

    logic               scan_wrap_s;
    logic               frame_end_s;
    logic               step_s;
    logic               blank_s;
    logic [AW-1:0]      rd_addr_s;
    logic [5:0]         rd_entry_s;
    logic [7:0]         seg_nxt_s;
    logic [NUM_DIG-1:0] dig_nxt_s;

    // Scan position decode, buffer read address and next display pattern.
    always_comb begin
        scan_wrap_s = (scan_cnt_r == SCAN_LAST);
        frame_end_s = scan_wrap_s && (idx_r == IDX_LAST);
        step_s      = frame_end_s && (frame_cnt_r == FRM_LAST);
        blank_s     = ({{(32-SCW){1'b0}}, scan_cnt_r} < 32'(BLANK_WIN));
        // Leftmost digit (highest idx) shows msg[offset]; wraps by truncation.
        rd_addr_s   = offset_r + LEFT_OFS - AW'(idx_r);
        rd_entry_s  = msg_r[rd_addr_s];
        if (blank_s) begin
            seg_nxt_s = 8'hFF;
            dig_nxt_s = {NUM_DIG{1'b1}};
        end else begin
            seg_nxt_s = {~rd_entry_s[5], seg_decode(rd_entry_s[4:0])};
            dig_nxt_s = ~(NUM_DIG'(1) << idx_r);
        end
    end

    // Slot timer, digit index, frame counter and scroll offset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r  <= {SCW{1'b0}};
            idx_r       <= {IW{1'b0}};
            frame_cnt_r <= {FW{1'b0}};
            offset_r    <= {AW{1'b0}};
        end else begin
            if (scan_wrap_s) begin
                scan_cnt_r <= {SCW{1'b0}};
                if (idx_r == IDX_LAST) begin
                    idx_r <= {IW{1'b0}};
                end else begin
                    idx_r <= idx_r + IW'(1);
                end
            end else begin
                scan_cnt_r <= scan_cnt_r + SCW'(1);
            end

            if (step_s) begin
                frame_cnt_r <= {FW{1'b0}};
            end else if (frame_end_s) begin
                frame_cnt_r <= frame_cnt_r + FW'(1);
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end

            // Clearing scroll_en only freezes the offset where it is.
            if (step_s && bus.scroll_en) begin
                offset_r <= offset_r + AW'(1);
            end else begin
                offset_r <= offset_r;
            end
        end
    end

    // Message buffer: cleared to blank on reset, one write per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_r[i] <= BLANK_ENT;
            end
        end else begin
            if (bus.wr_en) begin
                msg_r[bus.wr_addr] <= bus.wr_data;
            end else begin
                msg_r[bus.wr_addr] <= msg_r[bus.wr_addr];
            end
        end
    end

    // Registered display pins and end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r        <= 8'hFF;
            dig_r        <= {NUM_DIG{1'b1}};
            frame_tick_r <= 1'b0;
        end else begin
            seg_r        <= seg_nxt_s;
            dig_r        <= dig_nxt_s;
            frame_tick_r <= frame_end_s;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.dig        = dig_r;
    assign bus.frame_tick = frame_tick_r;
endmodule

// File: tb/tb_seg_scan_scroll.sv
// Testbench for seg_scan_scroll (NUM_DIG=4, SCAN_DIV=4, MSG_LEN=8,
// SCROLL_FRAMES=2, BLANK_CYC=1). A behavioural reference pushes the expected
// pin state per clock into a scoreboard queue; each scenario task pops and
// compares, and adds fixed-value checks of the documented glyphs.
module tb_seg_scan_scroll;
    logic clk;
    logic rst;

    seg_scan_scroll_if #(.NUM_DIG(4), .MSG_LEN(8)) bus ();

    seg_scan_scroll #(
        .NUM_DIG(4), .SCAN_DIV(4), .MSG_LEN(8), .SCROLL_FRAMES(2), .BLANK_CYC(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] dig;
        logic       ft;
    } obs_t;

    obs_t       sb_q [$];
    logic [5:0] m_msg [8];
    int         m_scan, m_idx, m_frame, m_off;
    int         n_vec = 0;
    int         n_err = 0;

    // Full message after the write and scroll scenarios: C P E 1 6 6 X L.
    logic [4:0] orig_code [8] = '{5'd12, 5'd18, 5'd14, 5'd1, 5'd6, 5'd6, 5'd20, 5'd17};
    logic [7:0] exp_left  [8] = '{8'hC6, 8'h8C, 8'h86, 8'hF9, 8'h82, 8'h82, 8'h89, 8'hC7};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        logic [6:0] g;
        case (c)
            5'd0: g = 7'h40;  5'd1: g = 7'h79;  5'd2: g = 7'h24;  5'd3: g = 7'h30;
            5'd4: g = 7'h19;  5'd5: g = 7'h12;  5'd6: g = 7'h02;  5'd7: g = 7'h78;
            5'd8: g = 7'h00;  5'd9: g = 7'h10;  5'd10: g = 7'h08; 5'd11: g = 7'h03;
            5'd12: g = 7'h46; 5'd13: g = 7'h21; 5'd14: g = 7'h06; 5'd15: g = 7'h0E;
            5'd16: g = 7'h09; 5'd17: g = 7'h47; 5'd18: g = 7'h0C; 5'd19: g = 7'h41;
            5'd20: g = 7'h09; 5'd21: g = 7'h3F;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_msg[i] = 6'd31;
        m_scan = 0; m_idx = 0; m_frame = 0; m_off = 0;
        sb_q.delete();
    endtask

    // Advance one clock: push expected pins for this edge, then update model.
    task automatic tick();
        logic [5:0] e;
        logic       blank;
        obs_t       o;
        @(posedge clk);
        if (!rst) begin
`ifdef GHOST_BLANK_EN
            blank = (m_scan < 1);
`else
            blank = 1'b0;
`endif
            e = m_msg[(m_off + 3 - m_idx) % 8];
            o.ft = (m_scan == 3 && m_idx == 3);
            if (blank) begin
                o.seg = 8'hFF;
                o.dig = 4'hF;
            end else begin
                o.seg = {~e[5], glyph(e[4:0])};
                o.dig = ~(4'b0001 << m_idx);
            end
            sb_q.push_back(o);
            if (bus.wr_en) m_msg[bus.wr_addr] = bus.wr_data;
            if (m_scan == 3) begin
                m_scan = 0;
                if (m_idx == 3) begin
                    m_idx = 0;
                    if (m_frame == 1) begin
                        m_frame = 0;
                        if (bus.scroll_en) m_off = (m_off + 1) % 8;
                    end else begin
                        m_frame = m_frame + 1;
                    end
                end else begin
                    m_idx = m_idx + 1;
                end
            end else begin
                m_scan = m_scan + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        obs_t o, x;
        logic [3:0] ed;
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 6'd0; bus.scroll_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.seg, bus.dig, bus.frame_tick} !== {8'hFF, 4'hF, 1'b0}) begin
            n_err++;
            $display("FAIL reset_hold got seg=%h dig=%b ft=%b want seg=ff dig=1111 ft=0", bus.seg, bus.dig, bus.frame_tick);
        end
        @(negedge clk); rst = 1'b0; model_reset();
        repeat (6) begin
            tick();
            o = {bus.seg, bus.dig, bus.frame_tick};
            x = sb_q.pop_front();
            n_vec++;
            if (o !== x) begin n_err++; $display("FAIL sb_reset got %h want %h", o, x); end
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.seg, bus.dig, bus.frame_tick} !== {8'hFF, 4'hF, 1'b0}) begin
            n_err++;
            $display("FAIL reset_async got seg=%h dig=%b ft=%b want seg=ff dig=1111 ft=0", bus.seg, bus.dig, bus.frame_tick);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0; model_reset();
        for (int k = 0; k < 16; k++) begin
            tick();
`ifdef GHOST_BLANK_EN
            ed = (k % 4 == 0) ? 4'hF : ~(4'b0001 << (k / 4));
`else
            ed = ~(4'b0001 << (k / 4));
`endif
            n_vec++;
            if (bus.dig !== ed || bus.seg !== 8'hFF) begin
                n_err++;
                $display("FAIL reset_scan k=%0d got dig=%b seg=%h want dig=%b seg=ff", k, bus.dig, bus.seg, ed);
            end
            o = {bus.seg, bus.dig, bus.frame_tick};
            x = sb_q.pop_front();
            n_vec++;
            if (o !== x) begin n_err++; $display("FAIL sb_reset_scan got %h want %h", o, x); end
        end
    endtask

    task automatic test_write();
        obs_t o, x;
        logic [7:0] es;
        int nblank, exp_blank;
        nblank = 0;
        for (int i = 0; i < 4; i++) begin   // back-to-back writes
            bus.wr_en = 1'b1; bus.wr_addr = 3'(i); bus.wr_data = {1'b0, orig_code[i]};
            tick();
            o = {bus.seg, bus.dig, bus.frame_tick};
            x = sb_q.pop_front();
            n_vec++;
            if (o !== x) begin n_err++; $display("FAIL sb_write got %h want %h", o, x); end
        end
        bus.wr_en = 1'b0;
        tick(); void'(sb_q.pop_front());
        for (int k = 0; k < 32; k++) begin
            tick();
            o = {bus.seg, bus.dig, bus.frame_tick};
            x = sb_q.pop_front();
            n_vec++;
            if (o !== x) begin n_err++; $display("FAIL sb_show got %h want %h", o, x); end
            case (bus.dig)
                4'b0111: es = 8'hC6;
                4'b1011: es = 8'h8C;
                4'b1101: es = 8'h86;
                4'b1110: es = 8'hF9;
                default: begin es = 8'hFF; nblank++; end
            endcase
            n_vec++;
            if (bus.seg !== es) begin n_err++; $display("FAIL show_glyph dig=%b got seg=%h want %h", bus.dig, bus.seg, es); end
        end
`ifdef GHOST_BLANK_EN
        exp_blank = 8;
`else
        exp_blank = 0;
`endif
        n_vec++;
        if (nblank != exp_blank) begin n_err++; $display("FAIL blank_count got %0d want %0d", nblank, exp_blank); end
    endtask

    task automatic test_scroll();
        obs_t o, x;
        int nft, off_before;
        for (int i = 4; i < 8; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 3'(i); bus.wr_data = {1'b0, orig_code[i]};
            tick();
            o = {bus.seg, bus.dig, bus.frame_tick};
            x = sb_q.pop_front();
            n_vec++;
            if (o !== x) begin n_err++; $display("FAIL sb_wr2 got %h want %h", o, x); end
        end
        bus.wr_en = 1'b0;
        bus.scroll_en = 1'b1;
        nft = 0;
        for (int k = 0; k < 288; k++) begin
            off_before = m_off;
            tick();
            if (bus.frame_tick === 1'b1) nft++;
            o = {bus.seg, bus.dig, bus.frame_tick};
            x = sb_q.pop_front();
            n_vec++;
            if (o !== x) begin n_err++; $display("FAIL sb_scroll got %h want %h", o, x); end
            if (bus.dig === 4'b0111) begin
                n_vec++;
                if (bus.seg !== exp_left[off_before]) begin
                    n_err++;
                    $display("FAIL scroll_left off=%0d got %h want %h", off_before, bus.seg, exp_left[off_before]);
                end
            end
        end
        n_vec++;
        if (nft != 18) begin n_err++; $display("FAIL frame_tick_count got %0d want 18", nft); end
    endtask

    task automatic test_dp();
        obs_t o, x;
        int a, guard;
        bus.scroll_en = 1'b0;
        guard = 0;
        while (!(m_idx == 2 && m_scan == 1) && guard < 64) begin
            tick(); void'(sb_q.pop_front()); guard++;
        end
        n_vec++;
        if (guard >= 64) begin n_err++; $display("FAIL dp_wait timeout got %0d want <64", guard); end
        a = (m_off + 1) % 8;
        bus.wr_en = 1'b1; bus.wr_addr = 3'(a); bus.wr_data = {1'b1, 5'd3};
        tick();
        o = {bus.seg, bus.dig, bus.frame_tick};
        x = sb_q.pop_front();
        n_vec++;
        if (o !== x) begin n_err++; $display("FAIL sb_dp_old got %h want %h", o, x); end
        bus.wr_en = 1'b0;
        tick();
        n_vec++;
        if (bus.seg !== 8'h30 || bus.dig !== 4'b1011) begin
            n_err++;
            $display("FAIL dp_new got seg=%h dig=%b want seg=30 dig=1011", bus.seg, bus.dig);
        end
        o = {bus.seg, bus.dig, bus.frame_tick};
        x = sb_q.pop_front();
        n_vec++;
        if (o !== x) begin n_err++; $display("FAIL sb_dp_new got %h want %h", o, x); end
        // Restore the original character for the following scenarios.
        bus.wr_en = 1'b1; bus.wr_data = {1'b0, orig_code[a]};
        tick(); void'(sb_q.pop_front());
        bus.wr_en = 1'b0;
    endtask

    task automatic test_hold();
        obs_t o, x;
        int guard;
        bus.scroll_en = 1'b1;
        guard = 0;
        while (m_off != 5 && guard < 400) begin
            tick(); void'(sb_q.pop_front()); guard++;
        end
        n_vec++;
        if (guard >= 400) begin n_err++; $display("FAIL hold_wait timeout got %0d want <400", guard); end
        bus.scroll_en = 1'b0;
        for (int k = 0; k < 192; k++) begin
            tick();
            o = {bus.seg, bus.dig, bus.frame_tick};
            x = sb_q.pop_front();
            n_vec++;
            if (o !== x) begin n_err++; $display("FAIL sb_hold got %h want %h", o, x); end
            if (k > 0 && bus.dig === 4'b0111) begin
                n_vec++;
                if (bus.seg !== 8'h82) begin n_err++; $display("FAIL hold_left got %h want 82", bus.seg); end
            end
        end
        bus.scroll_en = 1'b1;
        guard = 0;
        while (guard < 100) begin
            tick(); void'(sb_q.pop_front()); guard++;
            if (bus.dig === 4'b0111 && bus.seg !== 8'h82) break;
        end
        n_vec++;
        if (bus.seg !== 8'h89 || bus.dig !== 4'b0111) begin
            n_err++;
            $display("FAIL resume_left got seg=%h dig=%b want seg=89 dig=0111", bus.seg, bus.dig);
        end
    endtask

    task automatic test_simultaneous();
        obs_t o, x;
        int guard, a;
        bus.scroll_en = 1'b1;
        guard = 0;
        while (!(m_idx == 3 && m_scan == 3 && m_frame == 1) && guard < 64) begin
            tick(); void'(sb_q.pop_front()); guard++;
        end
        n_vec++;
        if (guard >= 64) begin n_err++; $display("FAIL simul_wait timeout got %0d want <64", guard); end
        // Write the entry the rightmost digit will show under the new offset.
        a = (m_off + 1 + 3) % 8;
        bus.wr_en = 1'b1; bus.wr_addr = 3'(a); bus.wr_data = {1'b0, 5'd21};
        tick();
        bus.wr_en = 1'b0;
        o = {bus.seg, bus.dig, bus.frame_tick};
        x = sb_q.pop_front();
        n_vec++;
        if (o !== x) begin n_err++; $display("FAIL sb_simul_edge got %h want %h", o, x); end
        repeat (2) begin
            tick();
            o = {bus.seg, bus.dig, bus.frame_tick};
            x = sb_q.pop_front();
            n_vec++;
            if (o !== x) begin n_err++; $display("FAIL sb_simul got %h want %h", o, x); end
        end
        n_vec++;
        if (bus.seg !== 8'hBF || bus.dig !== 4'b1110) begin
            n_err++;
            $display("FAIL simul_new got seg=%h dig=%b want seg=bf dig=1110", bus.seg, bus.dig);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_scroll();
        test_dp();
        test_hold();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
